// File: rtl/lpm_reduce_pipe.sv
// lpm_reduce_pipe: handshaked per-beat bitwise reduction, accumulated per packet, emitted through a register pipeline
module lpm_reduce_pipe #(
    parameter int lpm_width    = 8,
    parameter int lpm_size     = 4,
    parameter int lpm_pipeline = 2,
    parameter int lpm_cntw     = 8,
    parameter     lpm_type     = "lpm_reduce_pipe"
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [lpm_size*lpm_width-1:0] data,
    input  logic [1:0]                   op,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [lpm_width-1:0]         result,
    output logic [lpm_cntw-1:0]          out_beats,
    output logic                         out_any
);
    localparam logic [1:0] op_or = 2'b00, op_and = 2'b01, op_xor = 2'b10, op_nor = 2'b11;

    if (lpm_width <= 0 || lpm_size <= 0 || lpm_cntw <= 0 || lpm_pipeline < 1) begin : g_bad_params
        $fatal(1, "ERROR: %m illegal lpm_reduce_pipe parameters");
    end

    // NOR shares the OR datapath; its inversion happens only when the packet closes
    function automatic logic [lpm_width-1:0] combine(input logic [1:0] o,
                                                     input logic [lpm_width-1:0] a,
                                                     input logic [lpm_width-1:0] b);
        return o == op_and ? a & b : o == op_xor ? a ^ b : a | b;
    endfunction

    logic                 advance, accept, first;
    logic [1:0]           op_q, eff_op;
    logic [lpm_width-1:0] acc, beat_r, acc_nxt, fin;
    logic [lpm_cntw-1:0]  cnt, cnt_nxt;
    logic [lpm_pipeline-1:0] st_valid;
    logic [lpm_width-1:0] st_res   [lpm_pipeline];
    logic [lpm_cntw-1:0]  st_beats [lpm_pipeline];

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & advance;

    always_comb begin
        eff_op = first ? op : op_q;
        beat_r = data[lpm_width-1:0];
        for (int j = 1; j < lpm_size; j++)
            beat_r = combine(eff_op, beat_r, data[j*lpm_width +: lpm_width]);
        acc_nxt = first ? beat_r : combine(eff_op, acc, beat_r);
        cnt_nxt = first ? lpm_cntw'(1) : (&cnt ? cnt : cnt + lpm_cntw'(1));
        fin     = eff_op == op_nor ? ~acc_nxt : acc_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            cnt   <= '0;
            first <= 1'b1;
            op_q  <= op_or;
        end else if (accept) begin
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            op_q  <= eff_op;
            first <= in_last;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_valid <= '0;
            for (int k = 0; k < lpm_pipeline; k++) begin
                st_res[k]   <= '0;
                st_beats[k] <= '0;
            end
        end else if (advance) begin
            st_valid[0] <= accept & in_last;
            if (accept & in_last) begin
                st_res[0]   <= fin;
                st_beats[0] <= cnt_nxt;
            end
            for (int k = 1; k < lpm_pipeline; k++) begin
                st_valid[k] <= st_valid[k-1];
                st_res[k]   <= st_res[k-1];
                st_beats[k] <= st_beats[k-1];
            end
        end
    end

    assign out_valid = st_valid[lpm_pipeline-1];
    assign result    = st_res[lpm_pipeline-1];
    assign out_beats = st_beats[lpm_pipeline-1];
    assign out_any   = |result;
endmodule

// File: tb/tb_lpm_reduce_pipe.sv
// tb_lpm_reduce_pipe: directed table-driven bench for lpm_reduce_pipe, with a second instance at lpm_cntw=2
module tb_lpm_reduce_pipe;
    logic        clock = 1'b0;
    logic        reset_n, in_valid, in_last, out_ready;
    logic [31:0] data;
    logic [1:0]  op;
    logic        in_ready, out_valid, out_any;
    logic [7:0]  result, out_beats;
    logic        in_ready2, out_valid2, out_any2;
    logic [7:0]  result2;
    logic [1:0]  out_beats2;
    int          total = 0, bad = 0;

    always #5 clock = ~clock;

    lpm_reduce_pipe #(.lpm_width(8), .lpm_size(4), .lpm_pipeline(2), .lpm_cntw(8)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .data(data),
        .op(op), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_beats(out_beats), .out_any(out_any));

    lpm_reduce_pipe #(.lpm_width(8), .lpm_size(4), .lpm_pipeline(2), .lpm_cntw(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2), .data(data),
        .op(op), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
        .out_beats(out_beats2), .out_any(out_any2));

    typedef struct {
        logic [1:0]       op;
        int               n;
        logic [5:0][31:0] d;
        logic [7:0]       res;
        logic [7:0]       beats;
        logic [1:0]       beats2;
        logic             any;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic [7:0] beats;
        logic [1:0] beats2;
        logic       any;
    } exp_t;

    vec_t tbl[9];
    exp_t exp_q[$];
    exp_t e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, want, $time);
        end
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] b, input logic [1:0] b2, input logic a);
        exp_t x;
        x.res = r; x.beats = b; x.beats2 = b2; x.any = a;
        exp_q.push_back(x);
    endtask

    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("out_beats", out_beats, e.beats);
                chk("out_any", out_any, e.any);
                chk("dut2_valid", out_valid2, 1);
                chk("dut2_result", result2, e.res);
                chk("dut2_beats", out_beats2, e.beats2);
                chk("dut2_any", out_any2, e.any);
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [1:0] o, input logic last, input bit want_ready);
        bit got = 0;
        in_valid = 1; data = d; op = o; in_last = last;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (k == 0 && want_ready) chk("in_ready_held", in_ready, 1);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clock); #1;
        in_valid = 0; in_last = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge clock);
        chk("drain_left", exp_q.size(), 0);
        @(posedge clock); #1;
    endtask

    initial begin
        tbl[0] = '{2'b00, 1, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h01_02_04_80}, 8'h87, 8'd1, 2'd1, 1'b1};
        tbl[1] = '{2'b01, 3, {32'h0, 32'h0, 32'h0, 32'hFF_FF_FF_FE, 32'hFF_FF_3F_FF, 32'hFF_F0_FF_FF}, 8'h30, 8'd3, 2'd3, 1'b1};
        tbl[2] = '{2'b10, 1, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0F_0F_F0_F0}, 8'h00, 8'd1, 2'd1, 1'b0};
        tbl[3] = '{2'b11, 2, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 8'hFF, 8'd2, 2'd2, 1'b1};
        tbl[4] = '{2'b11, 1, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00_00_00_01}, 8'hFE, 8'd1, 2'd1, 1'b1};
        tbl[5] = '{2'b01, 1, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80_FF_FF_FF}, 8'h80, 8'd1, 2'd1, 1'b1};
        tbl[6] = '{2'b10, 2, {32'h0, 32'h0, 32'h0, 32'h0, 32'h00_00_00_03, 32'h01_00_00_00}, 8'h02, 8'd2, 2'd2, 1'b1};
        tbl[7] = '{2'b00, 6, {32'h20, 32'h10, 32'h08, 32'h04, 32'h02, 32'h01}, 8'h3F, 8'd6, 2'd3, 1'b1};
        tbl[8] = '{2'b11, 2, {32'h0, 32'h0, 32'h0, 32'h0, 32'h00_00_00_F0, 32'h00_00_00_0F}, 8'h00, 8'd2, 2'd2, 1'b0};

        reset_n = 0; in_valid = 0; in_last = 0; data = '0; op = '0; out_ready = 1;
        repeat (2) @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_out_beats", out_beats, 0);
        chk("rst_out_any", out_any, 0);
        @(posedge clock); #1;
        reset_n = 1;
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clock); #1;

        // latency: stage 1 after the accept edge, output one edge later
        push(8'h87, 8'd1, 2'd1, 1'b1);
        send_beat(32'h01_02_04_80, 2'b00, 1, 1);
        @(negedge clock);
        chk("lat_stage1_only", out_valid, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_result", result, 8'h87);
        drain();

        // later beats carry a different op that must be ignored
        for (int i = 0; i < 9; i++) begin
            push(tbl[i].res, tbl[i].beats, tbl[i].beats2, tbl[i].any);
            for (int b = 0; b < tbl[i].n; b++)
                send_beat(tbl[i].d[b], b == 0 ? tbl[i].op : tbl[i].op ^ 2'b10, b == tbl[i].n - 1, 0);
            drain();
        end

        for (int i = 0; i < 6; i++) begin
            push(8'h01 << i, 8'd1, 2'd1, 1'b1);
            send_beat({24'h0, 8'h01 << i}, 2'b00, 1, 1);
        end
        drain();

        push(8'h11, 8'd1, 2'd1, 1'b1);
        push(8'h22, 8'd1, 2'd1, 1'b1);
        push(8'h33, 8'd1, 2'd1, 1'b1);
        send_beat(32'h11, 2'b00, 1, 1);
        send_beat(32'h22, 2'b00, 1, 1);
        send_beat(32'h33, 2'b00, 1, 1);
        out_ready = 0;
        in_valid = 1; data = 32'h44; op = 2'b00; in_last = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_result", result, 8'h22);
            chk("stall_beats", out_beats, 8'd1);
            @(posedge clock); #1;
        end
        out_ready = 1;
        push(8'h44, 8'd1, 2'd1, 1'b1);
        send_beat(32'h44, 2'b00, 1, 1);
        drain();

        out_ready = 0;
        send_beat(32'h55, 2'b00, 1, 0);
        send_beat(32'h22, 2'b00, 0, 0);
        @(negedge clock);
        chk("pre_reset_valid", out_valid, 1);
        reset_n = 0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_result", result, 0);
        chk("async_rst_beats", out_beats, 0);
        chk("async_rst_any", out_any, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1;
        out_ready = 1;
        push(8'h11, 8'd1, 2'd1, 1'b1);
        send_beat(32'h11, 2'b00, 1, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
